// File: rtl/forwarder_pkg.sv
// Shared definitions for the transaction forwarder.
//   state_t                   : forwarder state encoding (IDLE, LOAD, SEND, DONE)
//   NUMBER_OF_QUEUES_DEFAULT  : default number of input FIFOs
//   ID_WIDTH                  : queue id width for the default queue count
package forwarder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NUMBER_OF_QUEUES_DEFAULT = 4;
  localparam int ID_WIDTH = $clog2(NUMBER_OF_QUEUES_DEFAULT);

endpackage

// File: rtl/wrapping_counter.sv
// Free-running unsigned event counter that wraps modulo 2^WIDTH.
//   clock : system clock
//   reset : synchronous, active-high clear
//   inc   : count one event this cycle
//   value : current count
module wrapping_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/transaction_forwarder.sv
// Pops the head of the queue selected by the scheduler's enable pulse and
// forwards it downstream over valid/ready, then returns a one-cycle consumed
// pulse to the scheduler.
//
// State table:
//   IDLE | waiting for an enable pulse
//   LOAD | one cycle: pop the selected head, or drop if its queue is empty
//   SEND | m_valid held until downstream accepts the word
//   DONE | one cycle: consumed pulse back to the scheduler
//
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   enable, id           : scheduler request and selected queue
//   empty, queue_data    : per-queue empty flags and FWFT head words
//   pop                  : one-hot dequeue strobe (combinational)
//   m_valid/m_ready      : downstream handshake, with m_data and m_id
//   consumed             : completion pulse
//   busy                 : high outside IDLE (combinational)
//   forwarded_count      : completed handshakes
//   drop_count           : enables that found their queue empty
//   overlap_error        : sticky, an enable arrived while busy
module transaction_forwarder
  import forwarder_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = NUMBER_OF_QUEUES_DEFAULT,
  parameter int DATA_WIDTH       = 64,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]          id,
  input  logic [NUMBER_OF_QUEUES-1:0]                  empty,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]  queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]                  pop,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [DATA_WIDTH-1:0]                        m_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]          m_id,
  output logic                                         consumed,
  output logic                                         busy,
  output logic [REGISTER_SIZE-1:0]                     forwarded_count,
  output logic [REGISTER_SIZE-1:0]                     drop_count,
  output logic                                         overlap_error
);

  localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ID_W-1:0]         r_id_q;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic [ID_W-1:0]         r_m_id;
  logic                    r_m_valid;
  logic                    r_consumed;
  logic                    r_overlap_error;

  logic                    w_id_in_range;
  logic [ID_W-1:0]         w_id_safe;
  logic                    w_head_ok;
  logic [NUMBER_OF_QUEUES-1:0] w_pop;
  logic                    w_busy;
  logic                    w_fwd_inc;
  logic                    w_drop_inc;

  // Ids beyond the queue count (non-power-of-2 builds) behave as an empty
  // queue; the safe index keeps the array selects in range.
  assign w_id_in_range = (32'(r_id_q) < NUMBER_OF_QUEUES);
  assign w_id_safe     = w_id_in_range ? r_id_q : '0;
  assign w_head_ok     = w_id_in_range && !empty[w_id_safe];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = '0;
    w_fwd_inc    = 1'b0;
    w_drop_inc   = 1'b0;
    w_busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (enable) w_next_state = LOAD;
      end
      LOAD: begin
        if (w_head_ok) begin
          w_pop[w_id_safe] = 1'b1;
          w_next_state     = SEND;
        end else begin
          w_drop_inc   = 1'b1;
          w_next_state = DONE;
        end
      end
      SEND: begin
        if (r_m_valid && m_ready) begin
          w_fwd_inc    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_id_q          <= '0;
      r_m_data        <= '0;
      r_m_id          <= '0;
      r_m_valid       <= 1'b0;
      r_consumed      <= 1'b0;
      r_overlap_error <= 1'b0;
    end else begin
      if (r_state == IDLE && enable) begin
        r_id_q <= id;
      end
      if (r_state == LOAD && w_head_ok) begin
        r_m_data  <= queue_data[w_id_safe];
        r_m_id    <= r_id_q;
        r_m_valid <= 1'b1;
      end
      if (w_fwd_inc) begin
        r_m_valid <= 1'b0;
      end
      // Registered so consumed is high exactly for the DONE cycle.
      r_consumed <= (w_next_state == DONE);
      if (enable && w_busy) begin
        r_overlap_error <= 1'b1;
      end
    end
  end

  wrapping_counter #(.WIDTH(REGISTER_SIZE)) u_forwarded_count (
    .clock (clock),
    .reset (reset),
    .inc   (w_fwd_inc),
    .value (forwarded_count)
  );

  wrapping_counter #(.WIDTH(REGISTER_SIZE)) u_drop_count (
    .clock (clock),
    .reset (reset),
    .inc   (w_drop_inc),
    .value (drop_count)
  );

  assign pop           = w_pop;
  assign busy          = w_busy;
  assign m_valid       = r_m_valid;
  assign m_data        = r_m_data;
  assign m_id          = r_m_id;
  assign consumed      = r_consumed;
  assign overlap_error = r_overlap_error;

endmodule

// File: tb/tb_transaction_forwarder.sv
// Randomized self-checking bench for transaction_forwarder. Each transaction
// is checked against the expected timeline: pop one cycle after enable, valid
// the cycle after, consumed one cycle after the handshake (or two cycles after
// enable on the drop path), with counters and the sticky overlap flag kept in
// a small transaction-level model.
module tb_transaction_forwarder;
  import forwarder_pkg::*;

  localparam int NQ = NUMBER_OF_QUEUES_DEFAULT;
  localparam int DW = 64;
  localparam int RS = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [ID_WIDTH-1:0]     id;
  logic [NQ-1:0]           empty;
  logic [NQ-1:0][DW-1:0]   queue_data;
  logic [NQ-1:0]           pop;
  logic                    m_valid;
  logic                    m_ready;
  logic [DW-1:0]           m_data;
  logic [ID_WIDTH-1:0]     m_id;
  logic                    consumed;
  logic                    busy;
  logic [RS-1:0]           forwarded_count;
  logic [RS-1:0]           drop_count;
  logic                    overlap_error;

  int n_vec = 0;
  int n_err = 0;

  logic [RS-1:0] exp_fwd  = '0;
  logic [RS-1:0] exp_drop = '0;
  logic          exp_ovl  = 1'b0;

  transaction_forwarder #(
    .NUMBER_OF_QUEUES (NQ),
    .DATA_WIDTH       (DW),
    .REGISTER_SIZE    (RS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .id              (id),
    .empty           (empty),
    .queue_data      (queue_data),
    .pop             (pop),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_id            (m_id),
    .consumed        (consumed),
    .busy            (busy),
    .forwarded_count (forwarded_count),
    .drop_count      (drop_count),
    .overlap_error   (overlap_error)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic randomize_queues();
    for (int q = 0; q < NQ; q++) begin
      queue_data[q] = {$urandom, $urandom};
      empty[q]      = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    expect_eq({tag, "_busy"},     64'(busy), 64'(0));
    expect_eq({tag, "_pop"},      64'(pop), 64'(0));
    expect_eq({tag, "_valid"},    64'(m_valid), 64'(0));
    expect_eq({tag, "_consumed"}, 64'(consumed), 64'(0));
    expect_eq({tag, "_fwd_cnt"},  64'(forwarded_count), 64'(exp_fwd));
    expect_eq({tag, "_drop_cnt"}, 64'(drop_count), 64'(exp_drop));
    expect_eq({tag, "_overlap"},  64'(overlap_error), 64'(exp_ovl));
  endtask

  // One complete request, started at a negedge while the DUT is IDLE.
  // ovl_where: 0 none, 1 extra enable in LOAD, 2 in SEND, 3 in DONE.
  task automatic do_txn(input int tid, input int stall, input int ovl_where, input int ovl_id);
    logic [DW-1:0] exp_data;
    logic          exp_empty;
    int            oid;
    oid       = (ovl_id >= 0) ? ovl_id : (tid + 1 + $urandom_range(0, NQ - 2)) % NQ;
    exp_empty = empty[tid];
    exp_data  = queue_data[tid];

    enable = 1'b1;
    id     = ID_WIDTH'(tid);
    @(negedge clock);
    expect_eq("pop_load", 64'(pop), exp_empty ? 64'(0) : 64'(1) << tid);
    expect_eq("busy_load", 64'(busy), 64'(1));
    expect_eq("valid_load", 64'(m_valid), 64'(0));
    expect_eq("consumed_load", 64'(consumed), 64'(0));
    m_ready = 1'b0;
    if (ovl_where == 1 || (exp_empty && ovl_where == 2)) begin
      id      = ID_WIDTH'(oid);
      exp_ovl = 1'b1;
    end else begin
      enable = 1'b0;
    end
    @(negedge clock);
    enable = 1'b0;
    expect_eq("pop_after_load", 64'(pop), 64'(0));
    if (exp_empty) begin
      exp_drop++;
      expect_eq("consumed_drop", 64'(consumed), 64'(1));
      expect_eq("valid_drop", 64'(m_valid), 64'(0));
    end else begin
      expect_eq("valid_send", 64'(m_valid), 64'(1));
      expect_eq("data_send", m_data, exp_data);
      expect_eq("id_send", 64'(m_id), 64'(tid));
      expect_eq("consumed_send", 64'(consumed), 64'(0));
      randomize_queues();
      if (ovl_where == 2) begin
        enable  = 1'b1;
        id      = ID_WIDTH'(oid);
        exp_ovl = 1'b1;
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        enable = 1'b0;
        expect_eq("valid_stall", 64'(m_valid), 64'(1));
        expect_eq("data_stall", m_data, exp_data);
        expect_eq("id_stall", 64'(m_id), 64'(tid));
        expect_eq("pop_stall", 64'(pop), 64'(0));
        expect_eq("consumed_stall", 64'(consumed), 64'(0));
      end
      m_ready = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      exp_fwd++;
      expect_eq("consumed_done", 64'(consumed), 64'(1));
      expect_eq("valid_done", 64'(m_valid), 64'(0));
      expect_eq("pop_done", 64'(pop), 64'(0));
    end
    expect_eq("busy_done", 64'(busy), 64'(1));
    if (ovl_where == 3) begin
      enable  = 1'b1;
      id      = ID_WIDTH'(oid);
      exp_ovl = 1'b1;
    end
    m_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    enable = 1'b0;
    check_idle_outputs("post");
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    id      = '0;
    m_ready = 1'b0;
    empty   = '0;
    for (int q = 0; q < NQ; q++) queue_data[q] = '0;
    repeat (3) @(negedge clock);
    expect_eq("rst_data", m_data, 64'(0));
    expect_eq("rst_id", 64'(m_id), 64'(0));
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clock);

    // Basic forward of queue 2.
    empty         = '0;
    queue_data[2] = 64'hA5A5;
    do_txn(2, 0, 0, -1);
    expect_eq("basic_fwd_cnt", 64'(forwarded_count), 64'(1));

    // Backpressure: five stalled cycles.
    randomize_queues();
    empty[0] = 1'b0;
    do_txn(0, 5, 0, -1);

    // Empty queue drop.
    randomize_queues();
    empty[1] = 1'b1;
    do_txn(1, 0, 0, -1);
    expect_eq("drop_cnt_one", 64'(drop_count), 64'(1));

    // Overlapping enable for queue 3 while queue 0 is being sent.
    randomize_queues();
    empty = '0;
    do_txn(0, 2, 2, 3);

    // Reset while m_valid is high.
    randomize_queues();
    empty[0] = 1'b0;
    enable   = 1'b1;
    id       = '0;
    @(negedge clock);
    enable  = 1'b0;
    m_ready = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    id     = ID_WIDTH'(1);
    @(negedge clock);
    enable = 1'b0;
    expect_eq("pre_rst_valid", 64'(m_valid), 64'(1));
    expect_eq("pre_rst_overlap", 64'(overlap_error), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    exp_fwd  = '0;
    exp_drop = '0;
    exp_ovl  = 1'b0;
    check_idle_outputs("mid_rst");
    expect_eq("mid_rst_data", m_data, 64'(0));

    // Back-to-back forwards, wrapping the 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      randomize_queues();
      empty = '0;
      do_txn(int'($urandom_range(0, NQ - 1)), 0, 0, -1);
    end
    expect_eq("wrap_fwd_cnt", 64'(forwarded_count), 64'(1));
    expect_eq("wrap_overlap", 64'(overlap_error), 64'(0));

    // Random mix.
    for (int k = 0; k < 200; k++) begin
      randomize_queues();
      do_txn(int'($urandom_range(0, NQ - 1)), int'($urandom_range(0, 4)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
      if ($urandom_range(0, 3) == 0) begin
        m_ready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clock);
        check_idle_outputs("gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/transaction_forwarder.md
Name: transaction_forwarder

Overview:
- Consumer-side counterpart of the queue scheduler. It takes the scheduler's one-cycle enable pulse and queue id, pops the head entry of that queue and forwards it downstream over a valid/ready handshake.
- On completion it returns a one-cycle consumed pulse to the scheduler. The scheduler edge-detects this pulse to release its pending transaction.
- Sits between the per-master FIFO bank and the memory-side port.

Parameters:
- NUMBER_OF_QUEUES, 4, number of input FIFOs; must be >= 2.
- DATA_WIDTH, 64, width of one queued transaction word.
- REGISTER_SIZE, 32, width of the statistics counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  one-cycle pulse from the scheduler: forward the head of queue id.
- id  input  $clog2(NUMBER_OF_QUEUES)  selected queue; sampled only when enable=1.
- empty  input  NUMBER_OF_QUEUES  per-queue empty flags.
- queue_data  input  NUMBER_OF_QUEUES x DATA_WIDTH  first-word-fall-through head of each queue; valid when ~empty.
- pop  output  NUMBER_OF_QUEUES  one-hot, one-cycle dequeue strobe.
- m_valid  output  1  downstream valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  forwarded word.
- m_id  output  $clog2(NUMBER_OF_QUEUES)  originating queue of m_data.
- consumed  output  1  one-cycle completion pulse to the scheduler.
- busy  output  1  high in any state other than IDLE.
- forwarded_count  output  REGISTER_SIZE  number of completed handshakes.
- drop_count  output  REGISTER_SIZE  number of enables that found their queue empty.
- overlap_error  output  1  sticky flag: an enable arrived while busy.

Behaviour:
- Reset:
  - State returns to IDLE; this applies at any cycle, including mid-operation.
  - pop, m_valid, consumed, busy and overlap_error go to 0.
  - m_data, m_id and both counters go to 0.
  - An entry popped before a reset is lost. This is intended; no replay is performed.
- All outputs are registered, except pop and busy, which are decoded combinationally from the state register and id_q.
- State machine, state encoding held in the shared package:
  - IDLE:
    - On enable=1, latch id into id_q and go to LOAD.
    - enable=0 keeps the state in IDLE.
  - LOAD (exactly 1 cycle):
    - If empty[id_q]=1: pop stays 0, drop_count increments, go to DONE.
    - Otherwise: pop[id_q]=1 for this cycle only, m_data<=queue_data[id_q], m_id<=id_q, go to SEND.
  - SEND:
    - m_valid=1, with m_data and m_id held stable, until the cycle where m_valid&m_ready.
    - On that handshake cycle: forwarded_count increments, m_valid<=0, go to DONE.
    - There is no timeout; m_ready low stalls indefinitely.
  - DONE (exactly 1 cycle):
    - consumed=1 during this cycle, then go to IDLE.
    - consumed is 0 in every other state, so every completion produces a rising edge.
- Latency:
  - enable at cycle T gives pop at T+1 and m_valid from T+2.
  - Handshake at cycle H gives consumed at H+1.
  - Minimum enable-to-consumed is 3 cycles.
  - The drop path (empty queue) gives consumed at T+2.
- Overlap:
  - enable while busy=1 is ignored: no state change and id_q is not overwritten.
  - overlap_error is set and stays set until reset.
- Simultaneous events:
  - enable in the DONE cycle counts as overlap.
  - enable in the first IDLE cycle after DONE is accepted normally.
- Counters are unsigned and wrap modulo 2^REGISTER_SIZE. There is no saturation.
- id values >= NUMBER_OF_QUEUES (non-power-of-2 configurations) are treated as an empty queue: drop path, with no pop asserted.

Decomposition:
- Package forwarder_pkg holds:
  - the state enum (IDLE, LOAD, SEND, DONE);
  - localparam ID_WIDTH = $clog2(NUMBER_OF_QUEUES).
- One sub-module, wrapping_counter:
  - parameter WIDTH;
  - inputs clock, reset, inc;
  - output value.
  - Instantiated twice: forwarded_count and drop_count.
- Queue mux and pop decode stay inline.

Test Plan:
- Basic forward: queue 2 holds 0xA5A5, m_ready=1, enable with id=2 at T -> pop=0100 at T+1; m_valid, m_data=0xA5A5, m_id=2 at T+2; consumed at T+3; forwarded_count=1.
- Backpressure: m_ready low for 5 cycles after m_valid rises -> m_data stable throughout; exactly one pop; consumed one cycle after m_ready rises.
- Empty drop: empty[1]=1, enable with id=1 -> pop never asserted, m_valid never asserted; consumed at T+2; drop_count=1.
- Overlap: second enable (id=3) during SEND of id=0 -> m_id stays 0, overlap_error=1; only one consumed pulse; queue 3 not popped.
- Reset mid-SEND: assert reset while m_valid=1 -> next cycle state IDLE; m_valid, consumed, counters and overlap_error all 0; a fresh enable then forwards normally.
- Back-to-back and wrap: REGISTER_SIZE=4, 17 consecutive forwards with enable issued one cycle after each consumed -> all accepted, no overlap_error, forwarded_count=1.
